// File: rtl/sdram_tester_pkg.sv
// Shared types and LFSR constants for the SDRAM pattern tester.
package sdram_tester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADDR    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_INVADDR = 2'd2,
    MODE_LFSR    = 2'd3
  } mode_e;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Test-pattern source shared by the write and compare paths; owns the LFSR
// state, every other mode is a pure function of the address.
module sdram_pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  mode_e             mode,
  input  logic [ADDR_W-1:0] address,
  input  logic              advance,
  input  logic              reseed,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] CHECKER = DATA_W'({16{2'b01}});

  logic [31:0] lfsr_q;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || reseed) begin
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    case (mode)
      MODE_ADDR:    data = DATA_W'(address);
      MODE_CHECKER: data = address[0] ? ~CHECKER : CHECKER;
      MODE_INVADDR: data = ~DATA_W'(address);
      default:      data = DATA_W'(lfsr_q);
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Write-then-read-back SDRAM tester: fills addresses 0..LAST_ADDR with a
// pattern, reads them back and records mismatches.
module sdram_pattern_tester
  import sdram_tester_pkg::*;
#(
  parameter int                ADDR_W    = 21,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1,
  parameter int                ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              loop,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got,
  output logic [15:0]       pass_count
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [15:0]       pass_q, pass_d;
  logic              req_q, req_d, loop_q, loop_d, done_q, done_d;
  logic              advance, reseed, at_last;
  logic [DATA_W-1:0] pat_data;

  assign at_last = (addr_q == LAST_ADDR);

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pat (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode_q),
    .address(addr_q),
    .advance(advance),
    .reseed (reseed),
    .data   (pat_data)
  );

  always_comb begin
    // NOTE: every _d takes its hold value first so no path through this block infers a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    req_d      = req_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    pass_d     = pass_q;
    advance    = 1'b0;
    reseed     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = WR_REQ;
          addr_d     = '0;
          req_d      = 1'b1;
          mode_d     = mode_e'(mode);
          loop_d     = loop;
          err_cnt_d  = '0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_got_d  = '0;
          pass_d     = '0;
          reseed     = 1'b1;
        end
      end
      WR_REQ, RD_REQ: begin
        if (stop) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end else if (!req_q) begin
          req_d = 1'b1;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          advance = 1'b1;
          if (state_q == RD_REQ && mem_rdata != pat_data) begin
            if (err_cnt_q == '0) begin
              err_addr_d = addr_q;
              err_exp_d  = pat_data;
              err_got_d  = mem_rdata;
            end
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          if (!at_last) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            // Each phase restarts the pattern so reads regenerate the written sequence.
            addr_d = '0;
            reseed = 1'b1;
            if (state_q == WR_REQ) begin
              state_d = RD_REQ;
            end else begin
              pass_d  = pass_q + 16'd1;
              done_d  = 1'b1;
              state_d = loop_q ? WR_REQ : DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ADDR;
      addr_q     <= '0;
      req_q      <= 1'b0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
      pass_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      loop_q     <= loop_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
      pass_q     <= pass_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = (state_q == WR_REQ);
  assign mem_addr   = addr_q;
  assign mem_wdata  = mem_we ? pat_data : '0;
  assign busy       = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign done       = done_q;
  assign err_count  = err_cnt_q;
  assign err_addr   = err_addr_q;
  assign err_exp    = err_exp_q;
  assign err_got    = err_got_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Self-checking bench: transaction-level model of the tester plus an SDRAM
// responder with programmable ack latency and read corruption.
module tb_sdram_pattern_tester;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int ERR_MAX = 15;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic        mem_req, mem_we, busy, done;
  logic        mem_ack = 1'b0;
  logic [3:0]  mem_addr, err_count, err_addr;
  logic [7:0]  mem_wdata, err_exp, err_got;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] pass_count;

  sdram_pattern_tester #(.ADDR_W(4), .DATA_W(8), .LAST_ADDR(4'd15), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode_i), .loop(loop_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .err_count(err_count), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
    .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference pattern: data of the k-th access in a phase.
  function automatic logic [31:0] gal_step(input logic [31:0] s_in);
    logic [31:0] s;
    logic        fb;
    fb = s_in[0];
    s  = s_in >> 1;
    if (fb) begin
      s[31] = ~s[31];
      s[21] = ~s[21];
      s[1]  = ~s[1];
      s[0]  = ~s[0];
    end
    return s;
  endfunction

  function automatic logic [7:0] pat(input int md, input int k);
    logic [31:0] s;
    logic [7:0]  kb;
    kb = k[7:0];
    s  = 32'h1;
    case (md)
      0: return kb;
      1: return (k % 2 == 1) ? 8'hAA : 8'h55;
      2: return ~kb;
      default: begin
        for (int i = 0; i < k; i++) s = gal_step(s);
        return s[7:0];
      end
    endcase
  endfunction

  // Environment and model state
  int         ack_lat = 3, fault_addr = -1, lat_cnt = 0;
  logic       fault_all = 1'b0, force_ack = 1'b0;
  logic [7:0] fault_xor = 8'h01;
  logic [7:0] mem_arr[16];
  bit         mon_en = 1'b0;
  bit         m_active = 0, m_in_done = 0, m_wr = 0, m_loop = 0, m_done_now = 0, prev_acc = 0;
  int         m_k = 0, m_mode = 0, m_err = 0, m_pass = 0;
  int         m_err_addr = 0, m_err_exp = 0, m_err_got = 0;
  int         n_wr = 0, n_rd = 0, n_done = 0;

  always @(negedge clk) begin
    logic [7:0] rd, ex;
    logic       acc;
    if (mon_en) begin
      check("busy", busy, 32'(m_active));
      check("done", done, 32'(m_done_now));
      check("err_count", err_count, m_err);
      check("err_addr", err_addr, m_err_addr);
      check("err_exp", err_exp, m_err_exp);
      check("err_got", err_got, m_err_got);
      check("pass_count", pass_count, m_pass);
      if (prev_acc || !m_active) check("req_idle_gap", mem_req, 0);
    end
    if (done === 1'b1) n_done++;

    // SDRAM responder
    if (rst || !mem_req) lat_cnt = 0;
    else lat_cnt++;
    mem_ack = force_ack || (mem_req && lat_cnt == ack_lat);
    rd = mem_arr[mem_addr];
    if (fault_all || int'(mem_addr) == fault_addr) rd = rd ^ fault_xor;
    mem_rdata = (mem_req && !mem_we) ? rd : 8'h00;

    // Model update for the coming rising edge
    acc        = mem_req && mem_ack;
    m_done_now = 0;
    prev_acc   = 0;
    if (rst) begin
      m_active = 0; m_in_done = 0; m_err = 0; m_pass = 0;
      m_err_addr = 0; m_err_exp = 0; m_err_got = 0;
    end else if (m_in_done) begin
      m_in_done = 0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active = 1; m_wr = 1; m_k = 0; m_mode = int'(mode_i); m_loop = loop_i;
        m_err = 0; m_pass = 0; m_err_addr = 0; m_err_exp = 0; m_err_got = 0;
        n_wr = 0; n_rd = 0;
      end
    end else if (stop) begin
      m_active = 0; m_in_done = 1; m_done_now = 1;
    end else if (acc) begin
      prev_acc = 1;
      ex = pat(m_mode, m_k);
      check("mem_we", mem_we, 32'(m_wr));
      check("mem_addr", mem_addr, m_k);
      if (m_wr) begin
        check("mem_wdata", mem_wdata, ex);
        mem_arr[mem_addr] = mem_wdata;
        n_wr++;
      end else begin
        n_rd++;
        if (mem_rdata != ex) begin
          if (m_err == 0) begin
            m_err_addr = m_k; m_err_exp = ex; m_err_got = mem_rdata;
          end
          if (m_err < ERR_MAX) m_err++;
        end
      end
      if (m_k == 15) begin
        m_k = 0;
        if (m_wr) m_wr = 0;
        else begin
          m_pass = (m_pass + 1) % 65536;
          m_done_now = 1;
          if (m_loop) m_wr = 1;
          else begin m_active = 0; m_in_done = 1; end
        end
      end else begin
        m_k++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int md, input bit lp);
    logic [1:0] mb;
    mb = md[1:0];
    mode_i = mb; loop_i = lp; n_done = 0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 4000) begin tick(); i++; end
    check({name, " finish"}, busy, 0);
    tick(); tick();
  endtask

  task automatic check_all_zero(input string name);
    check({name, " mem_req"}, mem_req, 0);
    check({name, " mem_we"}, mem_we, 0);
    check({name, " mem_addr"}, mem_addr, 0);
    check({name, " mem_wdata"}, mem_wdata, 0);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
    check({name, " err_count"}, err_count, 0);
    check({name, " err_addr"}, err_addr, 0);
    check({name, " err_exp"}, err_exp, 0);
    check({name, " err_got"}, err_got, 0);
    check({name, " pass_count"}, pass_count, 0);
  endtask

  initial begin
    int r, i, fa, md;

    // Model pins against hand-derived values
    check("pin mode0 k9", pat(0, 9), 8'h09);
    check("pin mode1 k6", pat(1, 6), 8'h55);
    check("pin mode1 k7", pat(1, 7), 8'hAA);
    check("pin mode2 k5", pat(2, 5), 8'hFA);
    check("pin lfsr k0", pat(3, 0), 8'h01);
    check("pin lfsr k1", pat(3, 1), 8'h03);
    check("pin lfsr k2", pat(3, 2), 8'h02);

    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    check_all_zero("reset");

    // Mode 0, clean memory, single pass; a start while busy must be ignored
    pulse_start(0, 0);
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("t1");
    check("t1 pass_count", pass_count, 1);
    check("t1 err_count", err_count, 0);
    check("t1 done pulses", n_done, 1);
    check("t1 writes", n_wr, 16);
    check("t1 reads", n_rd, 16);

    // start and stop together while idle: nothing starts
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    tick();
    check("start+stop busy", busy, 0);
    check("start+stop req", mem_req, 0);

    // Checkerboard with one corrupted read at address 6
    fault_addr = 6; fault_xor = 8'h01;
    pulse_start(1, 0);
    wait_idle("t2");
    check("t2 err_count", err_count, 1);
    check("t2 err_addr", err_addr, 6);
    check("t2 err_exp", err_exp, 8'h55);
    check("t2 err_got", err_got, 8'h54);
    fault_addr = -1;

    // LFSR, looping, stopped during the second read phase
    r = $urandom_range(1, 12);
    pulse_start(3, 1);
    i = 0;
    while (n_rd < 16 + r && i < 4000) begin tick(); i++; end
    check("t3 reached read phase", 32'(n_rd >= 16 + r), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    check("t3 busy after stop", busy, 0);
    force_ack = 1'b1; tick(); force_ack = 1'b0;
    tick(); tick();
    check("t3 pass_count", pass_count, 1);
    check("t3 done pulses", n_done, 2);
    check("t3 err_count", err_count, 0);
    check("t3 late ack busy", busy, 0);

    // Inverted address, every read corrupted, two passes: counter saturates
    fault_all = 1'b1; fault_xor = 8'h0F;
    pulse_start(2, 1);
    i = 0;
    while (pass_count != 16'd2 && i < 4000) begin tick(); i++; end
    check("t4 two passes", pass_count, 2);
    stop = 1'b1; tick(); stop = 1'b0;
    tick(); tick();
    check("t4 err_count sat", err_count, 15);
    check("t4 err_addr", err_addr, 0);
    check("t4 err_exp", err_exp, 8'hFF);
    check("t4 err_got", err_got, 8'hF0);
    check("t4 pass_count", pass_count, 2);
    check("t4 done pulses", n_done, 3);
    fault_all = 1'b0;

    // Randomized single passes
    for (int n = 0; n < 6; n++) begin
      md = $urandom_range(0, 3);
      ack_lat = $urandom_range(1, 4);
      fa = $urandom_range(0, 23);
      fault_addr = (fa <= 15) ? fa : -1;
      fault_xor = 8'($urandom_range(1, 255));
      pulse_start(md, 0);
      wait_idle("rand");
      check("rand err_count", err_count, (fa <= 15) ? 1 : 0);
      check("rand pass_count", pass_count, 1);
      if (fa <= 15) check("rand err_addr", err_addr, fa);
    end
    fault_addr = -1; ack_lat = 3;

    // Reset in the middle of the write to address 9
    pulse_start(0, 0);
    i = 0;
    while (!(mem_req && mem_we && mem_addr == 4'd9) && i < 4000) begin tick(); i++; end
    check("t6 reached addr 9", mem_addr, 9);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all_zero("t6 reset");
    force_ack = 1'b1; tick(); force_ack = 1'b0;
    tick(); tick();
    check("t6 late ack busy", busy, 0);
    check("t6 late ack req", mem_req, 0);
    check("t6 late ack addr", mem_addr, 0);
    check("t6 late ack pass", pass_count, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_pattern_tester.md
SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, memory address width in words.
REQ-002 SHALL have parameter DATA_W, default 8, data word width (1..32).
REQ-003 SHALL have parameter LAST_ADDR, default 2**ADDR_W-1, highest address tested.
REQ-004 SHALL have parameter ERR_W, default 16, error counter width.
REQ-005 SHALL run on one clock with a synchronous, active-high reset: clk input 1, sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a test when idle.
REQ-008 stop  input  1  one-cycle pulse; aborts the test.
REQ-009 mode  input  2  pattern select, sampled at start.
REQ-010 loop  input  1  repeat passes until stop, sampled at start.
REQ-011 mem_req  output  1  access request to the SDRAM controller.
REQ-012 mem_we  output  1  1 = write, 0 = read; valid with mem_req.
REQ-013 mem_addr  output  ADDR_W  access address.
REQ-014 mem_wdata  output  DATA_W  write data.
REQ-015 mem_ack  input  1  one-cycle pulse; access complete.
REQ-016 mem_rdata  input  DATA_W  read data, valid in the mem_ack cycle.
REQ-017 busy  output  1  test in progress.
REQ-018 done  output  1  one-cycle pulse when a pass completes or a stop takes effect.
REQ-019 err_count  output  ERR_W  saturating mismatch count since start.
REQ-020 err_addr / err_exp / err_got  output  ADDR_W / DATA_W / DATA_W  first mismatch address, expected data and read data.
REQ-021 pass_count  output  16  completed passes since start; wraps at 16'hFFFF.

Function
REQ-022 SHALL implement states IDLE, WR_REQ, RD_REQ and DONE.
REQ-023 IDLE with start=1 -> WR_REQ at address 0 on the next cycle; latch mode and loop; clear err_count, pass_count and the err_* outputs.
REQ-024 SHALL ignore start while busy.
REQ-025 In WR_REQ, SHALL hold mem_req=1, mem_we=1 and mem_addr/mem_wdata stable until mem_ack.
  - On mem_ack: next address.
  - On mem_ack at LAST_ADDR: RD_REQ at address 0.
REQ-026 In RD_REQ, SHALL hold mem_req=1 and mem_we=0 until mem_ack.
  - On mem_ack: compare mem_rdata with the regenerated pattern.
  - On mismatch: increment err_count, saturating at all-ones.
  - On mismatch with err_count==0: also capture err_addr, err_exp and err_got.
REQ-027 On the read mem_ack at LAST_ADDR, SHALL increment pass_count and pulse done.
  - loop=1: return to WR_REQ at address 0.
  - loop=0: go to DONE, then IDLE.
REQ-028 Patterns:
  - mode 0: data = address[DATA_W-1:0].
  - mode 1: data = 0x55.. when address[0]=0, else 0xAA.. (checkerboard).
  - mode 2: data = ~address[DATA_W-1:0].
  - mode 3: data = low DATA_W bits of a 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1, seed 32'h1, advanced once per acknowledged access and reseeded at the start of every write and read phase.
REQ-029 mem_req SHALL deassert in the cycle after mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-030 stop while busy: go to DONE next cycle, pulse done, leave pass_count unchanged.
  - An outstanding request SHALL be dropped; a later mem_ack is ignored.
REQ-031 start and stop in the same cycle while IDLE: stop wins; no test starts.
REQ-032 busy SHALL be 1 in WR_REQ and RD_REQ, 0 otherwise.

Reset
REQ-033 rst SHALL force IDLE regardless of state, including mid-access. It SHALL leave these at 0: mem_req, mem_we, mem_addr, mem_wdata, busy, done, err_count, err_addr, err_exp, err_got and pass_count. It SHALL also set the LFSR to seed 32'h1.
REQ-034 rst SHALL take priority over start, stop and mem_ack in the same cycle.

Structure
REQ-035 Package sdram_tester_pkg SHALL hold the state enum, the mode enum (MODE_ADDR, MODE_CHECKER, MODE_INVADDR, MODE_LFSR) and the LFSR taps/seed constants.
REQ-036 Pattern generation SHALL be one sub-module, sdram_pattern_gen, with inputs mode, address, advance and reseed, and output data. It is instantiated once and reused for write and compare.

Verification (ADDR_W=4, DATA_W=8, LAST_ADDR=15, ack 3 cycles after req)
REQ-037 Mode 0, no faults, loop=0 -> 16 writes of 0x00..0x0F, then 16 reads; done pulses once; pass_count=1; err_count=0.
REQ-038 Mode 1, model returns 0x54 at address 6 -> err_count=1, err_addr=6, err_exp=0x55, err_got=0x54.
REQ-039 Mode 3, loop=1, stop pulsed during the 2nd read phase -> pass_count=1; done pulses once per completed pass plus once at stop; busy=0 two cycles after stop.
REQ-040 Mode 2, every read corrupted, ERR_W=4, loop=1 for 2 passes -> err_count saturates at 15; err_addr=0 (first error only).
REQ-041 rst asserted while mem_req=1 in WR_REQ at address 9 -> next cycle mem_req=0, busy=0 and all outputs 0; a late mem_ack causes no state change.
